// File: rtl/timer_bank_pkg.sv
// Shared register-map constants and types for the multi-channel timer bank.
package timer_bank_pkg;

  localparam logic [1:0] OFF_CTRL    = 2'd0;
  localparam logic [1:0] OFF_LOAD    = 2'd1;
  localparam logic [1:0] OFF_COUNT   = 2'd2;
  localparam logic [1:0] OFF_STATUS  = 2'd3;
  localparam logic [1:0] OFF_PRESC   = 2'd0;
  localparam logic [1:0] OFF_DONEALL = 2'd1;

  localparam int unsigned CTRL_EN       = 0;
  localparam int unsigned CTRL_PERIODIC = 1;
  localparam int unsigned CTRL_IRQ_EN   = 2;

  typedef struct packed {
    logic irq_en;
    logic periodic;
    logic en;
  } ctrl_t;

  typedef enum logic {
    CH_IDLE,
    CH_RUN
  } ch_state_t;

endpackage

// File: rtl/timer_channel.sv
// One down-counter channel: CTRL/LOAD registers, sticky DONE flag and IDLE/RUN FSM.
module timer_channel
  import timer_bank_pkg::*;
#(
  parameter int unsigned CNT_W = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             tick,
  input  logic             wr_ctrl,
  input  logic             wr_load,
  input  logic             w1c,
  input  logic [31:0]      wdata,
  output logic [CNT_W-1:0] count,
  output logic [CNT_W-1:0] load,
  output logic             done,
  output ctrl_t            ctrl
);

  ch_state_t state;
  logic      disable_wr;
  logic      run_tick;
  logic      expire;

  // A CTRL write that clears EN pre-empts any tick in the same cycle.
  always_comb begin
    disable_wr = wr_ctrl && !wdata[CTRL_EN];
    run_tick   = (state == CH_RUN) && tick && !disable_wr;
    expire     = run_tick && (count <= CNT_W'(1));
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= CH_IDLE;
      ctrl  <= '0;
      load  <= '0;
      count <= '0;
      done  <= 1'b0;
    end else begin
      if (wr_load) load <= wdata[CNT_W-1:0];
      if (wr_ctrl) begin
        ctrl.en       <= wdata[CTRL_EN];
        ctrl.periodic <= wdata[CTRL_PERIODIC];
        ctrl.irq_en   <= wdata[CTRL_IRQ_EN];
      end
      if (w1c) done <= 1'b0;
      if (expire) done <= 1'b1;
      case (state)
        CH_IDLE: begin
          if (wr_ctrl && wdata[CTRL_EN]) begin
            count <= load;
            state <= CH_RUN;
          end
        end
        CH_RUN: begin
          if (disable_wr) begin
            state <= CH_IDLE;
          end else if (run_tick) begin
            if (!expire) begin
              count <= count - CNT_W'(1);
            end else if (ctrl.periodic) begin
              count <= load;
            end else begin
              count   <= '0;
              ctrl.en <= 1'b0;
              state   <= CH_IDLE;
            end
          end
        end
        default: state <= CH_IDLE;
      endcase
    end
  end

endmodule

// File: rtl/timer_bank.sv
// Memory-mapped bank of N_CH timers sharing one prescaler; reads are combinational.
module timer_bank
  import timer_bank_pkg::*;
#(
  parameter int unsigned N_CH    = 4,
  parameter int unsigned CNT_W   = 32,
  parameter int unsigned PRESC_W = 16,
  parameter int unsigned AW      = $clog2((N_CH + 1) * 4)
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [AW-1:0]   addr,
  input  logic [31:0]     wdata,
  input  logic            we,
  output logic [31:0]     rdata,
  output logic [N_CH-1:0] done_o,
  output logic            irq
);

  localparam int unsigned SW = AW - 2;

  logic [SW-1:0]      sel;
  logic [1:0]         off;
  logic               glob_hit;
  logic               wr_presc;
  logic [PRESC_W-1:0] presc;
  logic [PRESC_W-1:0] presc_cnt;
  logic               tick;

  logic [CNT_W-1:0]   count_q [N_CH];
  logic [CNT_W-1:0]   load_q  [N_CH];
  ctrl_t              ctrl_q  [N_CH];
  logic [N_CH-1:0]    done_vec;
  logic [N_CH-1:0]    irq_en_vec;

  assign sel      = addr[AW-1:2];
  assign off      = addr[1:0];
  assign glob_hit = (32'(sel) == N_CH);
  assign wr_presc = we && glob_hit && (off == OFF_PRESC);
  assign tick     = (presc_cnt == presc);

  always_ff @(posedge clk) begin
    if (reset) begin
      presc     <= '0;
      presc_cnt <= '0;
    end else if (wr_presc) begin
      presc     <= wdata[PRESC_W-1:0];
      presc_cnt <= '0;
    end else if (tick) begin
      presc_cnt <= '0;
    end else begin
      presc_cnt <= presc_cnt + PRESC_W'(1);
    end
  end

  for (genvar k = 0; k < N_CH; k++) begin : g_ch
    logic hit;
    assign hit = we && (32'(sel) == k);

    timer_channel #(
      .CNT_W(CNT_W)
    ) u_ch (
      .clk    (clk),
      .reset  (reset),
      .tick   (tick),
      .wr_ctrl(hit && (off == OFF_CTRL)),
      .wr_load(hit && (off == OFF_LOAD)),
      .w1c    (hit && (off == OFF_STATUS) && wdata[0]),
      .wdata  (wdata),
      .count  (count_q[k]),
      .load   (load_q[k]),
      .done   (done_vec[k]),
      .ctrl   (ctrl_q[k])
    );

    assign irq_en_vec[k] = ctrl_q[k].irq_en;
  end

  assign done_o = done_vec;
  assign irq    = |(done_vec & irq_en_vec);

  always_comb begin
    rdata = '0;
    for (int unsigned i = 0; i < N_CH; i++) begin
      if (32'(sel) == i) begin
        case (off)
          OFF_CTRL:   rdata = 32'(ctrl_q[i]);
          OFF_LOAD:   rdata = 32'(load_q[i]);
          OFF_COUNT:  rdata = 32'(count_q[i]);
          OFF_STATUS: rdata = 32'(done_vec[i]);
          default:    rdata = '0;
        endcase
      end
    end
    if (glob_hit) begin
      case (off)
        OFF_PRESC:   rdata = 32'(presc);
        OFF_DONEALL: rdata = 32'(done_vec);
        default:     rdata = '0;
      endcase
    end
  end

endmodule

// File: tb/tb_timer_bank.sv
// Directed self-checking bench for timer_bank with hand-computed expectations.
module tb_timer_bank;

  logic        clk = 1'b0;
  logic        reset;
  logic [4:0]  addr;
  logic [31:0] wdata;
  logic        we;
  logic [31:0] rdata;
  logic [3:0]  done_o;
  logic        irq;

  int n_chk  = 0;
  int n_fail = 0;

  timer_bank #(
    .N_CH   (4),
    .CNT_W  (32),
    .PRESC_W(16)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .addr  (addr),
    .wdata (wdata),
    .we    (we),
    .rdata (rdata),
    .done_o(done_o),
    .irq   (irq)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  // Called while clk is low; the write is taken on the next rising edge.
  task automatic wr(input logic [4:0] a, input logic [31:0] d);
    addr  = a;
    wdata = d;
    we    = 1'b1;
    @(negedge clk);
    we    = 1'b0;
  endtask

  task automatic chkrd(input string tag, input logic [4:0] a, input logic [31:0] exp);
    addr = a;
    #1;
    chk(tag, rdata, exp);
  endtask

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1;
    we    = 1'b0;
    addr  = '0;
    wdata = '0;
    cyc(3);
    reset = 1'b0;

    for (int k = 0; k < 4; k++)
      for (int o = 0; o < 4; o++)
        chkrd($sformatf("rst_a%0d", 4 * k + o), 5'(4 * k + o), 32'h0);
    chkrd("rst_presc", 5'd16, 32'h0);
    chkrd("rst_doneall", 5'd17, 32'h0);
    chk("rst_done_o", 32'(done_o), 32'h0);
    chk("rst_irq", 32'(irq), 32'h0);

    // ch0 one-shot, PRESC=0, LOAD=5
    wr(5'd16, 32'd0);
    wr(5'd1, 32'd5);
    chkrd("ch0_load_rb", 5'd1, 32'd5);
    wr(5'd0, 32'h1);
    chkrd("ch0_count_loaded", 5'd2, 32'd5);
    cyc(4);
    chkrd("ch0_count_pre", 5'd2, 32'd1);
    chk("ch0_done_pre", 32'(done_o), 32'h0);
    cyc(1);
    chk("ch0_done", 32'(done_o), 32'h1);
    chkrd("ch0_count_zero", 5'd2, 32'd0);
    chkrd("ch0_ctrl_en_off", 5'd0, 32'h0);
    chk("ch0_irq_low", 32'(irq), 32'h0);
    wr(5'd2, 32'd99);
    chkrd("ch0_count_ro", 5'd2, 32'd0);
    wr(5'd20, 32'hFF);
    chkrd("unmapped_rd", 5'd20, 32'h0);
    wr(5'd3, 32'h1);
    chk("ch0_w1c", 32'(done_o), 32'h0);

    // ch1 periodic with irq, PRESC=3, LOAD=2: expiries 6 and 14 edges after CTRL
    wr(5'd16, 32'd3);
    wr(5'd5, 32'd2);
    wr(5'd4, 32'h7);
    cyc(5);
    chk("ch1_done_pre1", 32'(done_o), 32'h0);
    chk("ch1_irq_pre1", 32'(irq), 32'h0);
    cyc(1);
    chk("ch1_done1", 32'(done_o), 32'h2);
    chk("ch1_irq1", 32'(irq), 32'h1);
    chkrd("ch1_status1", 5'd7, 32'h1);
    chkrd("ch1_reload", 5'd6, 32'd2);
    wr(5'd7, 32'h1);
    chk("ch1_w1c_done", 32'(done_o), 32'h0);
    chk("ch1_w1c_irq", 32'(irq), 32'h0);
    cyc(6);
    chk("ch1_done_pre2", 32'(done_o), 32'h0);
    cyc(1);
    chk("ch1_done2", 32'(done_o), 32'h2);
    chk("ch1_irq2", 32'(irq), 32'h1);
    wr(5'd4, 32'h0);
    wr(5'd7, 32'h1);
    chk("ch1_stopped", 32'(done_o), 32'h0);
    chkrd("ch1_count_hold", 5'd6, 32'd2);
    wr(5'd16, 32'd0);

    // ch2 periodic LOAD=4, LOAD rewritten to 10 mid-count
    wr(5'd9, 32'd4);
    wr(5'd8, 32'h3);
    wr(5'd9, 32'd10);
    chkrd("ch2_count_keep", 5'd10, 32'd3);
    cyc(2);
    chk("ch2_done_pre1", 32'(done_o), 32'h0);
    cyc(1);
    chk("ch2_done1", 32'(done_o), 32'h4);
    chkrd("ch2_reload10", 5'd10, 32'd10);
    wr(5'd11, 32'h1);
    chkrd("ch2_count9", 5'd10, 32'd9);
    cyc(8);
    chk("ch2_done_pre2", 32'(done_o), 32'h0);
    chkrd("ch2_count1", 5'd10, 32'd1);
    cyc(1);
    chk("ch2_done2", 32'(done_o), 32'h4);
    wr(5'd8, 32'h0);
    wr(5'd11, 32'h1);
    chk("ch2_stopped", 32'(done_o), 32'h0);

    // ch0: W1C in the expiry cycle, then CTRL disable in the expiry cycle
    wr(5'd0, 32'h1);
    cyc(4);
    wr(5'd3, 32'h1);
    chk("w1c_vs_set", 32'(done_o), 32'h1);
    chkrd("w1c_doneall", 5'd17, 32'h1);
    wr(5'd3, 32'h1);
    chk("w1c_clear", 32'(done_o), 32'h0);
    wr(5'd0, 32'h1);
    cyc(4);
    wr(5'd0, 32'h0);
    chk("ctrl_vs_expiry", 32'(done_o), 32'h0);
    chkrd("ctrl_vs_exp_cnt", 5'd2, 32'd1);

    // ch1 LOAD=0 periodic: expiry every tick, W1C loses to set
    wr(5'd5, 32'd0);
    wr(5'd4, 32'h3);
    cyc(1);
    chk("load0_done", 32'(done_o), 32'h2);
    wr(5'd7, 32'h1);
    chk("load0_w1c_set", 32'(done_o), 32'h2);
    wr(5'd4, 32'h0);
    wr(5'd7, 32'h1);
    chk("load0_cleared", 32'(done_o), 32'h0);

    // ch3 reset mid-count
    wr(5'd13, 32'd6);
    wr(5'd12, 32'h1);
    cyc(3);
    chkrd("rst_mid_cnt3", 5'd14, 32'd3);
    reset = 1'b1;
    cyc(1);
    reset = 1'b0;
    chkrd("rst_mid_cnt", 5'd14, 32'd0);
    chkrd("rst_mid_ctrl", 5'd12, 32'h0);
    chk("rst_mid_done", 32'(done_o), 32'h0);
    cyc(10);
    chk("rst_mid_noexp", 32'(done_o), 32'h0);
    chk("rst_mid_irq", 32'(irq), 32'h0);
    chkrd("rst_mid_doneall", 5'd17, 32'h0);
    chkrd("rst_mid_load0", 5'd1, 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
